// File: rtl/dmem_io.sv
// dmem_io: data-side memory for the single-cycle core: a local word RAM plus an IO region whose
// stores are posted through a FIFO. Define DMEM_IO_STATUS_EN to make IO-region loads return status.
module dmem_io #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter logic [31:0] IO_BASE    = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        io_valid,
  output logic [7:0]  io_addr,
  output logic [31:0] io_data,
  input  logic        io_ready,
  output logic        io_overflow
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  logic             is_io;
  logic             ctl_wr;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             full;
  logic             drop;
  logic [RamAw-1:0] ram_idx;

  logic [31:0] ram       [RAM_WORDS];
  logic [7:0]  fifo_addr [FIFO_DEPTH];
  logic [31:0] fifo_data [FIFO_DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  assign is_io    = (Addr >= IO_BASE);
  assign ram_idx  = Addr[RamAw+1:2];
  assign ctl_wr   = MemWrite && is_io && (Addr[7:0] == 8'hFC);
  assign push_req = MemWrite && is_io && (Addr[7:0] != 8'hFC);
  assign full     = (count_q == CntFull);
  assign pop      = io_valid && io_ready;
  // A pop frees the head slot in the same edge, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    if (ctl_wr) begin
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage arrays are not reset; outputs are gated by io_valid instead.
  always_ff @(posedge clk) begin
    if (MemWrite && !is_io) begin
      ram[ram_idx] <= WriteData;
    end
    if (push) begin
      fifo_addr[wr_ptr_q] <= Addr[7:0];
      fifo_data[wr_ptr_q] <= WriteData;
    end
  end

  assign io_valid    = (count_q != '0);
  assign io_addr     = io_valid ? fifo_addr[rd_ptr_q] : 8'h00;
  assign io_data     = io_valid ? fifo_data[rd_ptr_q] : 32'h0;
  assign io_overflow = overflow_q;

  always_comb begin
    ReadData = ram[ram_idx];
    if (is_io) begin
`ifdef DMEM_IO_STATUS_EN
      ReadData = {overflow_q, {(31 - CntW){1'b0}}, count_q};
`else
      ReadData = 32'h0;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_io.sv
// Self-checking bench for dmem_io: a table of per-cycle vectors plus a hand-written
// asynchronous-reset sequence. Honours DMEM_IO_STATUS_EN for IO-load expectations.
module tb_dmem_io;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        io_valid;
  logic [7:0]  io_addr;
  logic [31:0] io_data;
  logic        io_ready;
  logic        io_overflow;

  int checks;
  int errors;

`ifdef DMEM_IO_STATUS_EN
  localparam bit StatusEn = 1'b1;
`else
  localparam bit StatusEn = 1'b0;
`endif

  dmem_io dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .io_valid   (io_valid),
    .io_addr    (io_addr),
    .io_data    (io_data),
    .io_ready   (io_ready),
    .io_overflow(io_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] rd;
    logic        v;
    logic [7:0]  a;
    logic [31:0] d;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  // Expected IO-region load value for a given overflow flag and FIFO count.
  function automatic logic [31:0] st(input logic ovf, input int cnt);
    logic [31:0] r;
    r = {ovf, 28'h0, 3'(cnt)};
    return StatusEn ? r : 32'h0;
  endfunction

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic rdy, input logic chk_rd, input logic [31:0] rd,
                              input logic v, input logic [7:0] a, input logic [31:0] d,
                              input logic ovf);
    vec_t x;
    x.we = we; x.addr = addr; x.wd = wd; x.rdy = rdy; x.chk_rd = chk_rd; x.rd = rd;
    x.v = v; x.a = a; x.d = d; x.ovf = ovf;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rdy);
    MemWrite  = we;
    Addr      = addr;
    WriteData = wd;
    io_ready  = rdy;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);

    // Each vector: inputs for one cycle and the outputs seen before that cycle's edge.
    // RAM store/load, aliasing, ignored Addr[1:0], no write bypass.
    vecs.push_back(mk(1, 32'h10,   32'hDEADBEEF, 0, 0, 32'h0,       0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 32'h10,   32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 32'h110,  32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 32'h13,   32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(1, 32'h10,   32'hCAFEF00D, 0, 1, 32'hDEADBEEF, 0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 32'h10,   32'h0,        0, 1, 32'hCAFEF00D, 0, 8'h00, 32'h0, 0));
    // Posted write and single pop.
    vecs.push_back(mk(1, 32'h1004, 32'h55,       0, 1, st(0, 0),     0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(0, 32'h10,   32'h0,        0, 1, 32'hCAFEF00D, 1, 8'h04, 32'h55, 0));
    vecs.push_back(mk(0, 32'h10,   32'h0,        1, 0, 32'h0,       1, 8'h04, 32'h55, 0));
    vecs.push_back(mk(0, 32'h10,   32'h0,        0, 0, 32'h0,       0, 8'h00, 32'h0, 0));
    // Fill with 1..5; the fifth is dropped.
    vecs.push_back(mk(1, 32'h1000, 32'd1,        0, 0, 32'h0,       0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(1, 32'h1000, 32'd2,        0, 0, 32'h0,       1, 8'h00, 32'd1, 0));
    vecs.push_back(mk(1, 32'h1000, 32'd3,        0, 0, 32'h0,       1, 8'h00, 32'd1, 0));
    vecs.push_back(mk(1, 32'h1000, 32'd4,        0, 1, st(0, 3),     1, 8'h00, 32'd1, 0));
    vecs.push_back(mk(1, 32'h1000, 32'd5,        0, 1, st(0, 4),     1, 8'h00, 32'd1, 0));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        0, 1, st(1, 4),     1, 8'h00, 32'd1, 1));
    // Drain.
    vecs.push_back(mk(0, 32'h1000, 32'h0,        1, 0, 32'h0,       1, 8'h00, 32'd1, 1));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        1, 0, 32'h0,       1, 8'h00, 32'd2, 1));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        1, 0, 32'h0,       1, 8'h00, 32'd3, 1));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        1, 1, st(1, 1),     1, 8'h00, 32'd4, 1));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        0, 1, st(1, 0),     0, 8'h00, 32'h0, 1));
    // Control write clears overflow and is not enqueued.
    vecs.push_back(mk(1, 32'h10FC, 32'hFFFFFFFF, 0, 1, st(1, 0),     0, 8'h00, 32'h0, 1));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        0, 1, st(0, 0),     0, 8'h00, 32'h0, 0));
    // Full with simultaneous push and pop.
    vecs.push_back(mk(1, 32'h1008, 32'h11,       0, 0, 32'h0,       0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(1, 32'h1008, 32'h22,       0, 0, 32'h0,       1, 8'h08, 32'h11, 0));
    vecs.push_back(mk(1, 32'h1008, 32'h33,       0, 0, 32'h0,       1, 8'h08, 32'h11, 0));
    vecs.push_back(mk(1, 32'h1008, 32'h44,       0, 0, 32'h0,       1, 8'h08, 32'h11, 0));
    vecs.push_back(mk(1, 32'h1008, 32'hAA,       1, 1, st(0, 4),     1, 8'h08, 32'h11, 0));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        1, 1, st(0, 4),     1, 8'h08, 32'h22, 0));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        1, 0, 32'h0,       1, 8'h08, 32'h33, 0));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        1, 0, 32'h0,       1, 8'h08, 32'h44, 0));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        1, 1, st(0, 1),     1, 8'h08, 32'hAA, 0));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        0, 1, st(0, 0),     0, 8'h00, 32'h0, 0));
    // Control write with entries queued leaves count alone; queue three for the reset test.
    vecs.push_back(mk(1, 32'h1010, 32'h77,       0, 0, 32'h0,       0, 8'h00, 32'h0, 0));
    vecs.push_back(mk(1, 32'h1010, 32'h88,       0, 0, 32'h0,       1, 8'h10, 32'h77, 0));
    vecs.push_back(mk(1, 32'h10FC, 32'h0,        0, 1, st(0, 2),     1, 8'h10, 32'h77, 0));
    vecs.push_back(mk(1, 32'h1010, 32'h99,       0, 1, st(0, 2),     1, 8'h10, 32'h77, 0));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        0, 1, st(0, 3),     1, 8'h10, 32'h77, 0));

    #12 reset = 1'b0;
    @(negedge clk);
    check("reset io_valid", 32'(io_valid), 32'h0);
    check("reset io_addr", 32'(io_addr), 32'h0);
    check("reset io_data", io_data, 32'h0);
    check("reset io_overflow", 32'(io_overflow), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("v%0d io_valid", i), 32'(io_valid), 32'(vecs[i].v));
      check($sformatf("v%0d io_addr", i), 32'(io_addr), 32'(vecs[i].a));
      check($sformatf("v%0d io_data", i), io_data, vecs[i].d);
      check($sformatf("v%0d io_overflow", i), 32'(io_overflow), 32'(vecs[i].ovf));
      if (vecs[i].chk_rd) begin
        check($sformatf("v%0d ReadData", i), ReadData, vecs[i].rd);
      end
    end

    // Asynchronous reset between edges with three entries queued.
    @(posedge clk);
    #1;
    drive(1'b0, 32'h1000, 32'h0, 1'b0);
    @(negedge clk);
    check("pre-reset io_valid", 32'(io_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async reset io_valid", 32'(io_valid), 32'h0);
    check("async reset io_addr", 32'(io_addr), 32'h0);
    check("async reset io_data", io_data, 32'h0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b0, 32'h1000, 32'h0, 1'b1);
    @(negedge clk);
    check("post-reset io_valid", 32'(io_valid), 32'h0);
    check("post-reset status", ReadData, st(0, 0));
    @(posedge clk);
    #1;
    drive(1'b1, 32'h1020, 32'h5A, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h1000, 32'h0, 1'b0);
    @(negedge clk);
    check("post-reset push io_valid", 32'(io_valid), 32'h1);
    check("post-reset push io_addr", 32'(io_addr), 32'h20);
    check("post-reset push io_data", io_data, 32'h5A);
    check("post-reset push status", ReadData, st(0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
